// File: rtl/timekeep_pkg.sv
// Shared constants for the timekeeping chain: per-field widths, bounds and count direction.
package timekeep_pkg;

    localparam int SEC_W    = 6;
    localparam int MIN_W    = 6;
    localparam int HOUR_W   = 5;
    localparam int DAY_W    = 5;
    localparam int MON_W    = 4;
    localparam int YEAR_W   = 16;

    localparam int SEC_MAX  = 59;
    localparam int HOUR_MAX = 23;
    localparam int MON_MAX  = 12;
    localparam int DAY_MIN  = 1;
    localparam int MON_MIN  = 1;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/mod_counter_ext_if.sv
// Control and status bundle of one time-field counter; master drives requests, slave is the counter.
interface mod_counter_ext_if #(
    parameter int WIDTH = 16
);
    logic             enable;
    logic             up_down;
    logic             use_ext_max;
    logic [WIDTH-1:0] max_value;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             carry;
    logic             borrow;
    logic             tc;
    logic             load_err;

    modport master (
        output enable, up_down, use_ext_max, max_value, load, load_value,
        input  count, carry, borrow, tc, load_err
    );

    modport slave (
        input  enable, up_down, use_ext_max, max_value, load, load_value,
        output count, carry, borrow, tc, load_err
    );
endinterface

// File: rtl/mod_counter_clamp.sv
// Effective bound selection and load-value range clamp for mod_counter_ext (purely combinational).
module mod_counter_clamp #(
    parameter int WIDTH       = 16,
    parameter int MIN_VALUE   = 0,
    parameter int DEFAULT_MAX = 59
) (
    input  logic             i_use_ext_max,
    input  logic [WIDTH-1:0] i_max_value,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] o_bound,
    output logic [WIDTH-1:0] o_load_value,
    output logic             o_load_err
);
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VALUE);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(DEFAULT_MAX);

    logic [WIDTH-1:0] w_raw_bound;
    logic             w_bound_low;
    logic             w_load_low;
    logic             w_load_high;

    assign w_raw_bound = i_use_ext_max ? i_max_value : MAX_V;

    // A zero minimum can never be undershot; skipping the compare avoids a constant-false expression.
    if (MIN_VALUE == 0) begin : g_min_zero
        assign w_bound_low = 1'b0;
        assign w_load_low  = 1'b0;
    end else begin : g_min_nonzero
        assign w_bound_low = w_raw_bound < MIN_V;
        assign w_load_low  = i_load_value < MIN_V;
    end

    assign o_bound      = w_bound_low ? MIN_V : w_raw_bound;
    assign w_load_high  = i_load_value > o_bound;
    assign o_load_value = w_load_low  ? MIN_V :
                          w_load_high ? o_bound : i_load_value;
    assign o_load_err   = w_load_low | w_load_high;
endmodule

// File: rtl/mod_counter_ext.sv
// Up/down time-field counter with runtime bound, clamped load, pulse flags and lookahead terminal count.
module mod_counter_ext
    import timekeep_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int MIN_VALUE   = 0,
    parameter int DEFAULT_MAX = 59,
    parameter int RESET_VALUE = MIN_VALUE
) (
    input logic              clk,
    input logic              rst,
    mod_counter_ext_if.slave bus
);
    localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN_VALUE);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] r_count;
    logic             r_carry;
    logic             r_borrow;
    logic             r_load_err;

    logic [WIDTH-1:0] w_bound;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_load_err;
    logic             w_up;
    logic             w_at_top;
    logic             w_at_bottom;
    logic             w_above_bound;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_carry;
    logic             w_next_borrow;
    logic             w_next_load_err;

    mod_counter_clamp #(
        .WIDTH       (WIDTH),
        .MIN_VALUE   (MIN_VALUE),
        .DEFAULT_MAX (DEFAULT_MAX)
    ) u_clamp (
        .i_use_ext_max (bus.use_ext_max),
        .i_max_value   (bus.max_value),
        .i_load_value  (bus.load_value),
        .o_bound       (w_bound),
        .o_load_value  (w_load_clamped),
        .o_load_err    (w_load_err)
    );

    assign w_up          = (bus.up_down == DIR_UP);
    assign w_at_top      = r_count >= w_bound;
    assign w_at_bottom   = r_count <= MIN_V;
    assign w_above_bound = r_count > w_bound;

    // Lookahead so a downstream stage steps on the same edge as this one wraps.
    assign bus.tc = bus.enable & (w_up ? w_at_top : w_at_bottom);

    always_comb begin
        w_next_count    = r_count;
        w_next_carry    = 1'b0;
        w_next_borrow   = 1'b0;
        w_next_load_err = 1'b0;
        if (bus.load) begin
            w_next_count    = w_load_clamped;
            w_next_load_err = w_load_err;
        end else if (bus.enable) begin
            if (w_up) begin
                if (w_at_top) begin
                    w_next_count = MIN_V;
                    w_next_carry = 1'b1;
                end else begin
                    w_next_count = r_count + 1'b1;
                end
            end else begin
                // Below-minimum wraps to the bound; above a lowered bound only saturates.
                if (w_at_bottom) begin
                    w_next_count  = w_bound;
                    w_next_borrow = 1'b1;
                end else if (w_above_bound) begin
                    w_next_count  = w_bound;
                end else begin
                    w_next_count  = r_count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= RESET_V;
            r_carry    <= 1'b0;
            r_borrow   <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_count    <= w_next_count;
            r_carry    <= w_next_carry;
            r_borrow   <= w_next_borrow;
            r_load_err <= w_next_load_err;
        end
    end

    assign bus.count    = r_count;
    assign bus.carry    = r_carry;
    assign bus.borrow   = r_borrow;
    assign bus.load_err = r_load_err;
endmodule
